// File: rtl/mul_pkg.sv
// mul_pkg: shared types and constants for the shift-add multiplier.
//   mul_state_t : controller states (IDLE, CALC, DONE)
//   MUL_N       : default operand width
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int unsigned MUL_N = 16;

endpackage

// File: rtl/mul_fsm.sv
// mul_fsm: sequential shift-add unsigned multiplier with a start/busy/done handshake.
// It takes N cycles of iteration plus one DONE cycle per operation.
// Ports:
//   clk          : system clock, rising edge
//   reset        : asynchronous active-low reset
//   start        : request, sampled only in IDLE
//   multiplicand : operand A (N bits), captured on the accepted start edge
//   multiplier   : operand B (N bits), captured on the accepted start edge
//   product      : A*B (2N bits), loaded on DONE entry and held until the next result
//   busy         : high in CALC and DONE
//   done         : one-cycle pulse in DONE
module mul_fsm
  import mul_pkg::*;
#(
  parameter int unsigned N = MUL_N
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic           done
);

  localparam int unsigned CW = $clog2(N) + 1;

  mul_state_t r_state;
  mul_state_t w_state_next;

  logic [2*N-1:0] r_mcand;
  logic [N-1:0]   r_mplr;
  logic [2*N-1:0] r_acc;
  logic [CW-1:0]  r_cnt;
  logic [2*N-1:0] r_product;

  logic [2*N-1:0] w_addend;
  logic [2*N-1:0] w_sum;
  logic           w_last;

  // One shift-add step; the full 2N-bit sum is exact, so no carry out is needed.
  assign w_addend = r_mplr[0] ? r_mcand : '0;
  assign w_sum    = r_acc + w_addend;
  assign w_last   = (r_cnt == CW'(N - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_next = CALC;
      CALC:    if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        done = 1'b0;
      end
      CALC: busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand <= {{N{1'b0}}, multiplicand};
            r_mplr  <= multiplier;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        CALC: begin
          r_acc   <= w_sum;
          r_mcand <= r_mcand << 1;
          r_mplr  <= r_mplr >> 1;
          r_cnt   <= r_cnt + 1'b1;
          // Last iteration: publish the sum including this step's partial product.
          if (w_last) r_product <= w_sum;
        end
        default: ;
      endcase
    end
  end

  assign product = r_product;

endmodule
